rx_spatial_cb_masked: RTL

- N-lane receive channel bonder: merges N_CHANNEL per-lane AXI4-Stream beats of DWIDTH_IN bits into one N_CHANNEL*DWIDTH_IN beat.
- Successor to the fixed all-lane bonder, adding:
  - per-lane skew FIFOs of configurable depth;
  - a runtime lane-enable mask applied only at frame boundaries (degraded-lane operation);
  - lane-skew timeout and tlast-consistency error detection.
- Sits between the per-lane rifl_rx instances and the user RX AXI4-Stream, in the tx_frame_clk domain.

---
 rtl/rx_spatial_cb_masked_pkg.sv | 13 +
 rtl/rx_spatial_cb_masked_fifo.sv | 58 +++++
 rtl/rx_spatial_cb_masked.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rx_spatial_cb_masked_pkg.sv
// Shared types and helpers for the masked receive channel bonder.
package rifl_cb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } cb_state_t;

    function automatic int unsigned PTR_W(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_spatial_cb_masked_fifo.sv
// Per-lane first-word-fall-through skew FIFO with synchronous flush.
module cb_lane_fifo
    import rifl_cb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          din_i,
    output logic [WIDTH-1:0]          dout_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [PTR_W(DEPTH):0]     count_o
);

    localparam int unsigned AW = PTR_W(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

    // Pointers carry one extra wrap bit so full and empty are exact.
    assign count_o = wr_q - rd_q;
    assign full_o  = (count_o == DEPTH_V);
    assign empty_o = (wr_q == rd_q);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i && !full_o) wr_d = wr_q + 1'b1;
            if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/rx_spatial_cb_masked.sv
// N-lane receive channel bonder with per-lane skew FIFOs, frame-boundary lane
// masking, and sticky skew-timeout / tlast-consistency error flags.
module rx_spatial_cb_masked
    import rifl_cb_pkg::*;
#(
    parameter int unsigned          N_CHANNEL    = 4,
    parameter int unsigned          DWIDTH_IN    = 240,
    parameter int unsigned          DEPTH        = 8,
    parameter int unsigned          SKEW_TIMEOUT = 64,
    parameter logic [N_CHANNEL-1:0] MASK_DEFAULT = '1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DWIDTH_IN-1:0]              s_axis_tdata  [N_CHANNEL],
    input  logic [DWIDTH_IN/8-1:0]            s_axis_tkeep  [N_CHANNEL],
    input  logic [N_CHANNEL-1:0]              s_axis_tlast,
    input  logic [N_CHANNEL-1:0]              s_axis_tvalid,
    output logic [N_CHANNEL-1:0]              s_axis_tready,
    output logic [N_CHANNEL*DWIDTH_IN-1:0]    m_axis_tdata,
    output logic [N_CHANNEL*DWIDTH_IN/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic [N_CHANNEL-1:0]              lane_en_req,
    output logic [N_CHANNEL-1:0]              lane_en_active,
    input  logic                              clear_err,
    output logic                              skew_err,
    output logic                              tlast_err
);

    localparam int unsigned KW = DWIDTH_IN / 8;
    localparam int unsigned FW = DWIDTH_IN + KW + 1;
    localparam int unsigned AW = PTR_W(DEPTH);
    localparam int unsigned SW = $clog2(SKEW_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] SKEW_MAX = SW'(SKEW_TIMEOUT);

    logic [N_CHANNEL-1:0] full, empty, push, pop_lane, flush, lane_full, lane_empty;
    logic [FW-1:0]        head [N_CHANNEL];
    logic [AW:0]          occ  [N_CHANNEL];

    logic [N_CHANNEL-1:0]           mask_q, mask_d;
    cb_state_t                      state_q, state_d;
    logic                           tvalid_q, tvalid_d, tlast_q;
    logic [N_CHANNEL*DWIDTH_IN-1:0] tdata_q, beat_data;
    logic [N_CHANNEL*KW-1:0]        tkeep_q, beat_keep;
    logic [SW-1:0]                  skew_cnt_q, skew_cnt_d;
    logic                           skew_err_q, skew_err_d, tlast_err_q, tlast_err_d;
    logic                           pop, head_last, found, last_mis, mask_load, skew_cond;

    for (genvar g = 0; g < N_CHANNEL; g++) begin : g_lane
        assign push[g]          = mask_q[g] & s_axis_tvalid[g] & ~full[g];
        assign s_axis_tready[g] = ~mask_q[g] | ~full[g];
        assign lane_full[g]     = mask_q[g] & (occ[g] == DEPTH_V);
        assign lane_empty[g]    = mask_q[g] & (occ[g] == '0);

        cb_lane_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush[g]),
            .push_i  (push[g]),
            .pop_i   (pop_lane[g]),
            .din_i   ({s_axis_tlast[g], s_axis_tkeep[g], s_axis_tdata[g]}),
            .dout_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (occ[g])
        );
    end

    always_comb begin
        head_last = 1'b0;
        found     = 1'b0;
        last_mis  = 1'b0;
        beat_data = '0;
        beat_keep = '0;
        for (int unsigned i = 0; i < N_CHANNEL; i++) begin
            if (mask_q[i] && !found) begin
                head_last = head[i][FW-1];
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_CHANNEL; i++) begin
            if (mask_q[i]) begin
                if (head[i][FW-1] != head_last) last_mis = 1'b1;
                beat_data[i*DWIDTH_IN +: DWIDTH_IN] = head[i][DWIDTH_IN-1:0];
                beat_keep[i*KW +: KW]               = head[i][DWIDTH_IN +: KW];
            end
        end
    end

    assign pop      = (|mask_q) && ((empty & mask_q) == '0) && (!tvalid_q || m_axis_tready);
    assign pop_lane = pop ? mask_q : '0;

    // New mask only takes effect between frames; lanes whose bit flips restart empty.
    assign mask_load = (lane_en_req != mask_q) &&
                       (((state_q == IDLE) && !pop) || (pop && head_last));
    assign mask_d    = mask_load ? lane_en_req : mask_q;
    assign flush     = mask_load ? (lane_en_req ^ mask_q) : '0;
    assign skew_cond = (|lane_full) && (|lane_empty);

    always_comb begin
        state_d = state_q;
        if (pop) state_d = head_last ? IDLE : FRAME;

        tvalid_d = tvalid_q;
        if (pop)                tvalid_d = 1'b1;
        else if (m_axis_tready) tvalid_d = 1'b0;

        skew_cnt_d = '0;
        if (skew_cond) skew_cnt_d = (skew_cnt_q == SKEW_MAX) ? skew_cnt_q : skew_cnt_q + 1'b1;

        skew_err_d  = (skew_err_q & ~clear_err) | (skew_cond && (skew_cnt_d == SKEW_MAX));
        tlast_err_d = (tlast_err_q & ~clear_err) | (pop & last_mis);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= MASK_DEFAULT;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            skew_cnt_q  <= '0;
            skew_err_q  <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            tvalid_q    <= tvalid_d;
            skew_cnt_q  <= skew_cnt_d;
            skew_err_q  <= skew_err_d;
            tlast_err_q <= tlast_err_d;
            if (pop) begin
                tdata_q <= beat_data;
                tkeep_q <= beat_keep;
                tlast_q <= head_last;
            end
        end
    end

    assign m_axis_tdata   = tdata_q;
    assign m_axis_tkeep   = tkeep_q;
    assign m_axis_tlast   = tlast_q;
    assign m_axis_tvalid  = tvalid_q;
    assign lane_en_active = mask_q;
    assign skew_err       = skew_err_q;
    assign tlast_err      = tlast_err_q;

endmodule
